// File: rtl/pkg_tpu.sv
// Shared TPU types: address/stride widths and the DMem access manager state encoding.
package pkg_tpu;

    localparam int WIDTH_ADDR   = 12;
    localparam int WIDTH_STRIDE = 8;

    typedef logic [WIDTH_ADDR-1:0]   address_t;
    typedef logic [WIDTH_STRIDE-1:0] stride_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TERM = 2'd2,
        REL  = 2'd3
    } access_man_st_t;

    // Stride is unsigned and zero-extended; the sum wraps modulo 2^WIDTH_ADDR.
    function automatic address_t next_addr(input address_t addr, input stride_t stride);
        return addr + address_t'(stride);
    endfunction

endpackage

// File: rtl/stride_access_man_if.sv
// Grant-side and DMem-side signals of the strided access manager.
interface stride_access_man_if;
    import pkg_tpu::*;

    logic       I_GrantVld;
    logic [1:0] I_GrantNo;
    address_t   I_Length;
    stride_t    I_Stride;
    address_t   I_Base_Addr;
    logic       I_Stall;

    address_t   O_Addr;
    logic       O_Valid;
    logic       O_Last;
    logic       O_Busy;
    logic       O_Term1;
    logic       O_Term2;
    logic       O_Term3;

    modport master (
        output I_GrantVld, I_GrantNo, I_Length, I_Stride, I_Base_Addr, I_Stall,
        input  O_Addr, O_Valid, O_Last, O_Busy, O_Term1, O_Term2, O_Term3
    );

    modport slave (
        input  I_GrantVld, I_GrantNo, I_Length, I_Stride, I_Base_Addr, I_Stall,
        output O_Addr, O_Valid, O_Last, O_Busy, O_Term1, O_Term2, O_Term3
    );

endinterface

// File: rtl/stride_access_man.sv
// Walks a granted strided address sequence, one address per unstalled cycle,
// then pulses the granted lane's termination line and waits for the grant to drop.
module stride_access_man
    import pkg_tpu::*;
(
    input  logic                clock,
    input  logic                reset,
    stride_access_man_if.slave  bus
);

    access_man_st_t R_State;
    access_man_st_t w_next_state;
    address_t       R_Addr;
    address_t       R_Cnt;
    address_t       R_Len;
    stride_t        R_Stride;
    logic [1:0]     R_GrantNo;

    logic           w_start;
    logic           w_cnt_last;

    assign w_start    = bus.I_GrantVld && (bus.I_GrantNo != 2'b00);
    assign w_cnt_last = (R_Cnt == (R_Len - address_t'(1)));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            R_State <= IDLE;
        end else begin
            R_State <= w_next_state;
        end
    end

    // Capture of the grant and the address/count accumulators
    always_ff @(posedge clock) begin
        if (reset) begin
            R_Addr    <= '0;
            R_Cnt     <= '0;
            R_Len     <= '0;
            R_Stride  <= '0;
            R_GrantNo <= 2'b00;
        end else begin
            case (R_State)
                IDLE: begin
                    if (w_start) begin
                        R_Addr    <= bus.I_Base_Addr;
                        R_Cnt     <= '0;
                        R_Len     <= bus.I_Length;
                        R_Stride  <= bus.I_Stride;
                        R_GrantNo <= bus.I_GrantNo;
                    end
                end
                RUN: begin
                    if (bus.I_GrantVld && !bus.I_Stall) begin
                        R_Addr <= next_addr(R_Addr, R_Stride);
                        R_Cnt  <= R_Cnt + address_t'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state decode; an abort (grant dropped) wins over completion in RUN
    always_comb begin
        w_next_state = R_State;
        case (R_State)
            IDLE: begin
                if (w_start) begin
                    if (bus.I_Length == '0) begin
                        w_next_state = TERM;
                    end else begin
                        w_next_state = RUN;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (!bus.I_GrantVld) begin
                    w_next_state = IDLE;
                end else if (w_cnt_last && !bus.I_Stall) begin
                    w_next_state = TERM;
                end else begin
                    w_next_state = RUN;
                end
            end
            TERM: begin
                w_next_state = REL;
            end
            REL: begin
                if (!bus.I_GrantVld || (bus.I_GrantNo != R_GrantNo)) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = REL;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only
    always_comb begin
        bus.O_Addr  = '0;
        bus.O_Valid = 1'b0;
        bus.O_Last  = 1'b0;
        bus.O_Busy  = (R_State != IDLE);
        bus.O_Term1 = 1'b0;
        bus.O_Term2 = 1'b0;
        bus.O_Term3 = 1'b0;
        case (R_State)
            RUN: begin
                bus.O_Addr  = R_Addr;
                bus.O_Valid = 1'b1;
                bus.O_Last  = w_cnt_last;
            end
            TERM: begin
                case (R_GrantNo)
                    2'b01:   bus.O_Term1 = 1'b1;
                    2'b10:   bus.O_Term2 = 1'b1;
                    2'b11:   bus.O_Term3 = 1'b1;
                    default: bus.O_Term1 = 1'b0;
                endcase
            end
            default: begin
                bus.O_Busy = (R_State != IDLE);
            end
        endcase
    end

endmodule

// File: doc/stride_access_man.md
# stride_access_man

Data-memory access manager at the granted end of the lane arbitration protocol. Takes the winning grant (number, length, stride, base address) and walks the strided address sequence one address per cycle, honouring back-pressure. At completion it returns a one-cycle termination pulse to the granted lane, which releases that lane's grant in the arbiter. It sits between the DMem request arbiter and the DMem bank address port.

## Interface
Parameters:
- none; widths come from pkg_tpu: address_t (WIDTH_ADDR bits, unsigned), stride_t (WIDTH_STRIDE bits, unsigned)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- I_GrantVld  in  1  arbiter grant valid
- I_GrantNo  in  2  granted lane: 01/10/11; 00 = none
- I_Length  in  address_t  number of accesses
- I_Stride  in  stride_t  address increment per access
- I_Base_Addr  in  address_t  first address
- I_Stall  in  1  memory/lane back-pressure; holds current address
- O_Addr  out  address_t  current access address
- O_Valid  out  1  O_Addr valid this cycle
- O_Last  out  1  O_Valid and this is the final access
- O_Busy  out  1  FSM not in IDLE
- O_Term1 / O_Term2 / O_Term3  out  1 each  end-of-access pulse to lane 1/2/3

## Operation
- FSM states: IDLE, RUN, TERM, REL.
- IDLE:
  - Start when I_GrantVld=1 and I_GrantNo≠00.
  - On start, capture base into R_Addr, plus stride, length and grant number; clear counter R_Cnt.
  - If I_Length=0, go to TERM with no address issued; otherwise go to RUN.
- RUN:
  - O_Valid=1, O_Addr=R_Addr.
  - When I_Stall=0, the access is consumed: R_Addr += zero-extended stride, modulo 2^WIDTH_ADDR (wrap, no saturation), and R_Cnt += 1.
  - When I_Stall=1, R_Addr and R_Cnt hold.
  - O_Last=1 when R_Cnt = length−1.
  - If O_Last=1 and I_Stall=0, go to TERM.
- TERM: assert exactly one O_TermN, selected by the captured grant number, for one cycle; go to REL.
- REL:
  - Stay until I_GrantVld=0 or I_GrantNo differs from the captured number, then go to IDLE.
  - This prevents restarting on the stale grant.
  - A different grant seen here is not started until the IDLE cycle.
- Abort: if I_GrantVld=0 during RUN, go to IDLE next cycle. No term pulse is issued; O_Valid=0 from that cycle.
- Input changes on length/stride/base after capture are ignored.
- Reset:
  - State goes to IDLE; R_Addr, R_Cnt and captured registers go to 0.
  - All outputs are 0, including O_Addr.
  - Reset mid-RUN drops the transfer with no term pulse.

## Timing
- Start seen at cycle t → first O_Valid at t+1.
- No stalls: N addresses on cycles t+1..t+N; O_Last at t+N; O_TermN at t+N+1.
- Each stalled cycle in RUN adds one cycle.
- Arbiter drops the grant at t+N+2; REL exits that cycle; IDLE at t+N+3. The earliest next start is seen at t+N+3.
- All outputs are registered-state decodes; there is no combinational path from any input to any output.
- O_Term1..3 are mutually exclusive and never asserted while O_Valid=1.

## Structure
- pkg_tpu holds address_t and stride_t, already shared.
- Add typedef enum logic [1:0] access_man_st_t {IDLE, RUN, TERM, REL} to pkg_tpu.
- Single module; no sub-module needed. The address accumulator and counter are inline registers.

## Test plan
- Grant 01, base 0x010, stride 4, length 3, no stall → O_Addr 0x010/0x014/0x018 on t+1..t+3; O_Last at t+3; O_Term1 only at t+4.
- Same transfer with I_Stall=1 on t+2 → 0x014 held two cycles; O_Term1 moves to t+5; exactly 3 consumed addresses.
- Grant 11, length 0 → no O_Valid; O_Term3 at t+1.
- Base = 2^WIDTH_ADDR−2, stride 3, length 2 → addresses max−1 then 1 (wrap); O_Term of the granted lane after.
- Grant 10, length 8; I_GrantVld drops at the 3rd address → O_Valid low next cycle; no O_Term2; O_Busy=0.
- Reset asserted mid-RUN → all outputs 0 next cycle. A new grant 01 after reset then runs normally from its base.
